// File: rtl/remote_responder_pkg.sv
// ============================================================================
// remote_responder_pkg : shared constants and access decode for the responder
// Rev 1.0
// ============================================================================
`default_nettype none

package remote_responder_pkg;

    localparam int         WORD_W       = 16;
    localparam logic [1:0] LOCAL_REGION = 2'b00;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } access_t;

    // A write takes precedence when a core raises both enables.
    function automatic access_t decode_access(input logic valid, input logic wren,
                                              input logic rden);
        if (!valid)
            return ACC_IDLE;
        else if (wren)
            return ACC_WRITE;
        else if (rden)
            return ACC_READ;
        else
            return ACC_IDLE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dpsram.sv
// ============================================================================
// dpsram : dual-port synchronous SRAM, read-new-data on each port
// Rev 1.0
// ============================================================================
`default_nettype none

module dpsram #(
    parameter int DEPTH  = 4096,
    parameter int WIDTH  = 16,
    parameter int AWIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_a,
    input  logic [AWIDTH-1:0] addr_a,
    input  logic [WIDTH-1:0]  wdata_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic              we_b,
    input  logic [AWIDTH-1:0] addr_b,
    input  logic [WIDTH-1:0]  wdata_b,
    output logic [WIDTH-1:0]  rdata_b
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Port B is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (we_a)
            r_mem[addr_a] <= wdata_a;
        if (we_b)
            r_mem[addr_b] <= wdata_b;
        rdata_a <= we_a ? wdata_a : r_mem[addr_a];
        rdata_b <= we_b ? wdata_b : r_mem[addr_b];
    end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : one-hot round-robin arbiter, search starts at the rotating pointer
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_valid
);

    localparam int PW = $clog2(N);
    localparam logic [PW:0]   c_n_ext  = N[PW:0];
    localparam logic [PW-1:0] c_last   = PW'(N - 1);

    logic [PW-1:0] r_ptr;
    logic [PW:0]   w_pos;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        w_pos       = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = {1'b0, r_ptr} + k[PW:0];
            if (w_pos >= c_n_ext)
                w_pos = w_pos - c_n_ext;
            if (!grant_valid && req[w_pos[PW-1:0]]) begin
                grant_valid             = 1'b1;
                grant[w_pos[PW-1:0]]    = 1'b1;
                grant_idx               = w_pos[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ptr <= '0;
        else if (advance && grant_valid)
            r_ptr <= (grant_idx == c_last) ? '0 : grant_idx + 1'b1;
    end

endmodule

`default_nettype wire

// File: rtl/remote_responder.sv
// ============================================================================
// remote_responder : arbitrates per-core remote accesses onto one shared SRAM
// Rev 1.0
// ============================================================================
`default_nettype none

module remote_responder
    import remote_responder_pkg::*;
#(
    parameter int NUM_CORES   = 4,
    parameter int SHARED_SIZE = 4096
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [WORD_W*NUM_CORES-1:0] req_addr,
    input  logic [NUM_CORES-1:0]        req_wren,
    input  logic [NUM_CORES-1:0]        req_rden,
    input  logic [WORD_W*NUM_CORES-1:0] req_wdata,
    output logic [NUM_CORES-1:0]        req_ready,
    output logic [WORD_W*NUM_CORES-1:0] req_rdata
);

    localparam int SADDR_WIDTH = $clog2(SHARED_SIZE);
    localparam int PTR_W       = $clog2(NUM_CORES);

    logic [NUM_CORES-1:0]   w_req;
    logic [NUM_CORES-1:0]   w_grant;
    logic [PTR_W-1:0]       w_gidx;
    logic                   w_gvalid;
    logic [WORD_W-1:0]      w_addr;
    logic [WORD_W-1:0]      w_wdata;
    logic                   w_sel_wren;
    logic                   w_sel_rden;
    access_t                w_op;
    logic [SADDR_WIDTH-1:0] w_idx;
    logic [WORD_W-1:0]      w_q;
    logic [WORD_W-1:0]      w_q_b;

    logic                   r_rd_valid;
    logic [PTR_W-1:0]       r_rd_port;

    // Requests are masked during reset so ready drops the instant reset rises.
    assign w_req     = (req_wren | req_rden) & {NUM_CORES{~reset}};
    assign req_ready = w_grant;

    rr_arbiter #(
        .N (NUM_CORES)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (w_req),
        .advance     (w_gvalid),
        .grant       (w_grant),
        .grant_idx   (w_gidx),
        .grant_valid (w_gvalid)
    );

    always_comb begin
        w_addr     = '0;
        w_wdata    = '0;
        w_sel_wren = 1'b0;
        w_sel_rden = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_grant[i]) begin
                w_addr     = req_addr[i*WORD_W +: WORD_W];
                w_wdata    = req_wdata[i*WORD_W +: WORD_W];
                w_sel_wren = req_wren[i];
                w_sel_rden = req_rden[i];
            end
        end
    end

    assign w_op  = decode_access(w_gvalid, w_sel_wren, w_sel_rden);
    assign w_idx = w_addr[SADDR_WIDTH-1:0];

    dpsram #(
        .DEPTH (SHARED_SIZE),
        .WIDTH (WORD_W)
    ) u_mem (
        .clk     (clk),
        .we_a    (w_op == ACC_WRITE),
        .addr_a  (w_idx),
        .wdata_a (w_wdata),
        .rdata_a (w_q),
        .we_b    (1'b0),
        .addr_b  ('0),
        .wdata_b ('0),
        .rdata_b (w_q_b)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_port  <= '0;
        end else begin
            r_rd_valid <= (w_op == ACC_READ);
            r_rd_port  <= w_gidx;
        end
    end

    // Live SRAM output for the core whose read lands this cycle, held copy otherwise.
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_rdata
        logic [WORD_W-1:0] r_hold;
        logic              w_hit;

        assign w_hit = r_rd_valid && (r_rd_port == PTR_W'(i));

        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                r_hold <= '0;
            else if (w_hit)
                r_hold <= w_q;
        end

        assign req_rdata[i*WORD_W +: WORD_W] = w_hit ? w_q : r_hold;
    end

endmodule

`default_nettype wire

// File: tb/tb_remote_responder.sv
// ============================================================================
// tb_remote_responder : directed self-checking bench for remote_responder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_remote_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] addr;
    logic [3:0]  wren;
    logic [3:0]  rden;
    logic [63:0] wdata;
    logic [3:0]  ready;
    logic [63:0] rdata;

    int total = 0;
    int bad   = 0;

    remote_responder #(
        .NUM_CORES   (4),
        .SHARED_SIZE (4096)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_addr  (addr),
        .req_wren  (wren),
        .req_rden  (rden),
        .req_wdata (wdata),
        .req_ready (ready),
        .req_rdata (rdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int c, input logic [15:0] a, input logic w,
                           input logic r, input logic [15:0] d);
        addr[c*16 +: 16]  = a;
        wren[c]           = w;
        rden[c]           = r;
        wdata[c*16 +: 16] = d;
    endtask

    task automatic clr(input int c);
        wren[c] = 1'b0;
        rden[c] = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        addr  = '0;
        wdata = '0;
        wren  = '0;
        rden  = '0;
        tick();
        tick();
        total++;
        if (ready !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ready got=%h exp=0", ready);
        end
        total++;
        if (rdata !== 64'h0) begin
            bad++;
            $display("FAIL reset_rdata got=%h exp=0", rdata);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_sole_write_read;
        #1;
        total++;
        if (ready !== 4'b0000) begin
            bad++;
            $display("FAIL idle_ready got=%h exp=0", ready);
        end
        set_req(0, 16'h4010, 1'b1, 1'b0, 16'hBEEF);
        #1;
        total++;
        if (ready !== 4'b0001) begin
            bad++;
            $display("FAIL t1_write_ready got=%h exp=1", ready);
        end
        tick();
        set_req(0, 16'h4010, 1'b0, 1'b1, 16'h0000);
        #1;
        total++;
        if (ready !== 4'b0001) begin
            bad++;
            $display("FAIL t1_read_ready got=%h exp=1", ready);
        end
        tick();
        clr(0);
        total++;
        if (rdata[15:0] !== 16'hBEEF) begin
            bad++;
            $display("FAIL t1_rdata0 got=%h exp=beef", rdata[15:0]);
        end
    endtask

    task automatic test_all_read_order;
        logic [3:0]  exp_rdy;
        logic [15:0] exp_val;
        for (int i = 0; i < 4; i++) begin
            set_req(0, 16'h4100 + 16'(i), 1'b1, 1'b0, 16'(16'h1111 * (i + 1)));
            tick();
        end
        clr(0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++)
            set_req(i, 16'h4100 + 16'(i), 1'b0, 1'b1, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            exp_rdy = 4'b0001 << k;
            exp_val = 16'(16'h1111 * (k + 1));
            #1;
            total++;
            if (ready !== exp_rdy) begin
                bad++;
                $display("FAIL t2_grant%0d got=%h exp=%h", k, ready, exp_rdy);
            end
            tick();
            clr(k);
            total++;
            if (rdata[k*16 +: 16] !== exp_val) begin
                bad++;
                $display("FAIL t2_rdata%0d got=%h exp=%h", k, rdata[k*16 +: 16], exp_val);
            end
        end
    endtask

    task automatic test_alternation;
        set_req(1, 16'h4101, 1'b0, 1'b1, 16'h0000);
        set_req(2, 16'h4010, 1'b0, 1'b1, 16'h0000);
        #1;
        total++;
        if (ready !== 4'b0010) begin
            bad++;
            $display("FAIL t3_first got=%h exp=2", ready);
        end
        tick();
        total++;
        if (ready !== 4'b0100) begin
            bad++;
            $display("FAIL t3_second got=%h exp=4", ready);
        end
        tick();
        clr(2);
        #1;
        total++;
        if (ready !== 4'b0010) begin
            bad++;
            $display("FAIL t3_third got=%h exp=2", ready);
        end
        total++;
        if (rdata[47:32] !== 16'hBEEF) begin
            bad++;
            $display("FAIL t3_rdata2 got=%h exp=beef", rdata[47:32]);
        end
        tick();
        clr(1);
    endtask

    task automatic test_raw_alias;
        set_req(0, 16'h4005, 1'b1, 1'b0, 16'h1234);
        #1;
        total++;
        if (ready !== 4'b0001) begin
            bad++;
            $display("FAIL t4_wr_ready got=%h exp=1", ready);
        end
        tick();
        clr(0);
        set_req(3, 16'h4005, 1'b0, 1'b1, 16'h0000);
        #1;
        total++;
        if (ready !== 4'b1000) begin
            bad++;
            $display("FAIL t4_rd_ready got=%h exp=8", ready);
        end
        tick();
        clr(3);
        total++;
        if (rdata[63:48] !== 16'h1234) begin
            bad++;
            $display("FAIL t4_raw_rdata3 got=%h exp=1234", rdata[63:48]);
        end
        set_req(0, 16'h7005, 1'b1, 1'b0, 16'h5678);
        tick();
        set_req(0, 16'h4005, 1'b0, 1'b1, 16'h0000);
        tick();
        clr(0);
        total++;
        if (rdata[15:0] !== 16'h5678) begin
            bad++;
            $display("FAIL t4_alias_rdata0 got=%h exp=5678", rdata[15:0]);
        end
    endtask

    task automatic test_write_and_read;
        set_req(2, 16'h4200, 1'b1, 1'b1, 16'hAAAA);
        #1;
        total++;
        if (ready !== 4'b0100) begin
            bad++;
            $display("FAIL t5_ready got=%h exp=4", ready);
        end
        tick();
        clr(2);
        total++;
        if (rdata[47:32] !== 16'hBEEF) begin
            bad++;
            $display("FAIL t5_rdata2_kept got=%h exp=beef", rdata[47:32]);
        end
        tick();
        total++;
        if (rdata[47:32] !== 16'hBEEF) begin
            bad++;
            $display("FAIL t5_rdata2_later got=%h exp=beef", rdata[47:32]);
        end
        set_req(2, 16'h4200, 1'b0, 1'b1, 16'h0000);
        tick();
        clr(2);
        total++;
        if (rdata[47:32] !== 16'hAAAA) begin
            bad++;
            $display("FAIL t5_mem_written got=%h exp=aaaa", rdata[47:32]);
        end
    endtask

    task automatic test_reset_pending;
        set_req(1, 16'h4101, 1'b0, 1'b1, 16'h0000);
        tick();
        set_req(3, 16'h4103, 1'b0, 1'b1, 16'h0000);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (ready !== 4'b0000) begin
            bad++;
            $display("FAIL t6_ready_in_reset got=%h exp=0", ready);
        end
        total++;
        if (rdata !== 64'h0) begin
            bad++;
            $display("FAIL t6_rdata_in_reset got=%h exp=0", rdata);
        end
        tick();
        reset = 1'b0;
        #1;
        total++;
        if (ready !== 4'b0010) begin
            bad++;
            $display("FAIL t6_first_after_reset got=%h exp=2", ready);
        end
        tick();
        clr(1);
        total++;
        if (rdata[31:16] !== 16'h2222) begin
            bad++;
            $display("FAIL t6_rdata1 got=%h exp=2222", rdata[31:16]);
        end
        #1;
        total++;
        if (ready !== 4'b1000) begin
            bad++;
            $display("FAIL t6_second_after_reset got=%h exp=8", ready);
        end
        tick();
        clr(3);
        total++;
        if (rdata[63:48] !== 16'h4444) begin
            bad++;
            $display("FAIL t6_rdata3 got=%h exp=4444", rdata[63:48]);
        end
    endtask

    initial begin
        test_reset();
        test_sole_write_read();
        test_all_read_order();
        test_alternation();
        test_raw_alias();
        test_write_and_read();
        test_reset_pending();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
